path_delay_monitor: RTL and testbench

- Measurement end of the spy-path experiments: the monitored combinational path is closed into a ring oscillator; this block gates it, counts its oscillations over a programmable window and compares the count against a golden band.
- An inserted payload gate adds delay, which lowers the count and raises trojan_flag.
- Sits beside each path under test; one instance per path; results read by the test controller.

---
 rtl/path_delay_monitor.sv | 171 +++++++++++++++++
 tb/tb_path_delay_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_monitor.sv
// Ring-oscillator path delay monitor: gates the oscillator loop, counts its rising
// edges over a programmable window and flags counts outside a golden band.
module path_delay_monitor #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WIN_W         = 20,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] golden_min,
  input  logic [CNT_W-1:0] golden_max,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             trojan_flag,
  output logic             cfg_err
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic               rise_c;
  logic               cfg_bad_c;
  logic               reject_q;
  logic [WIN_W-1:0]   win_len_q;
  logic [WIN_W-1:0]   win_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   gmin_q;
  logic [CNT_W-1:0]   gmax_q;

  // Oscillator synchronizer and edge-history flop; free-running in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise_c    = sync_q[SYNC_STAGES-1] & ~prev_q;
    cfg_bad_c = (window_len == '0) || (golden_min > golden_max);
  end

  // Measurement sequencer; done is delayed one cycle from DONE / rejection so
  // that it lands SETTLE_CYCLES + window_len + 2 cycles after the start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ro_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      sat         <= 1'b0;
      trojan_flag <= 1'b0;
      cfg_err     <= 1'b0;
      reject_q    <= 1'b0;
      win_len_q   <= '0;
      win_cnt     <= '0;
      settle_cnt  <= '0;
      gmin_q      <= '0;
      gmax_q      <= '0;
    end else begin
      done     <= reject_q || (state == S_DONE);
      reject_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            win_len_q <= window_len;
            gmin_q    <= golden_min;
            gmax_q    <= golden_max;
            if (cfg_bad_c) begin
              cfg_err  <= 1'b1;
              reject_q <= 1'b1;
            end else begin
              cfg_err     <= 1'b0;
              count       <= '0;
              sat         <= 1'b0;
              trojan_flag <= 1'b0;
              settle_cnt  <= SETTLE_LOAD;
              ro_en       <= 1'b1;
              busy        <= 1'b1;
              state       <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state   <= S_IDLE;
            ro_en   <= 1'b0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
          end else if (settle_cnt == '0) begin
            win_cnt <= win_len_q - WIN_W'(1);
            state   <= S_MEASURE;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end

        S_MEASURE: begin
          if (abort) begin
            state   <= S_IDLE;
            ro_en   <= 1'b0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
          end else begin
            if (rise_c) begin
              if (count == '1) begin
                sat <= 1'b1;
              end else begin
                count <= count + CNT_W'(1);
              end
            end
            if (win_cnt == '0) begin
              ro_en <= 1'b0;
              state <= S_COMPARE;
            end else begin
              win_cnt <= win_cnt - WIN_W'(1);
            end
          end
        end

        S_COMPARE: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
          end else begin
            trojan_flag <= sat || (count < gmin_q) || (count > gmax_q);
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          ro_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_monitor.sv
// Bench for path_delay_monitor: modelled ring oscillators, directed scenarios and
// randomized windows/bands checked against an edges-per-window reference model.
module tb_path_delay_monitor;

  localparam int unsigned SETTLE = 16;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [19:0] window_len;
  logic [15:0] golden_min, golden_max;
  logic        ro_in, ro_en, busy, done, sat, trojan_flag, cfg_err;
  logic [15:0] count;

  logic        start8, abort8;
  logic [19:0] window_len8;
  logic [7:0]  golden_min8, golden_max8, count8;
  logic        ro_in8, ro_en8, busy8, done8, sat8, trojan_flag8, cfg_err8;

  int checks = 0;
  int errors = 0;
  int half_a = 20;
  int half_b = 20;

  path_delay_monitor #(.CNT_W(16), .WIN_W(20), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .window_len(window_len),
    .golden_min(golden_min), .golden_max(golden_max), .ro_in(ro_in), .ro_en(ro_en),
    .busy(busy), .done(done), .count(count), .sat(sat), .trojan_flag(trojan_flag),
    .cfg_err(cfg_err)
  );

  path_delay_monitor #(.CNT_W(8), .WIN_W(20), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .window_len(window_len8),
    .golden_min(golden_min8), .golden_max(golden_max8), .ro_in(ro_in8), .ro_en(ro_en8),
    .busy(busy8), .done(done8), .count(count8), .sat(sat8), .trojan_flag(trojan_flag8),
    .cfg_err(cfg_err8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gated ring oscillators; transitions kept off the clk edges
  initial begin
    ro_in = 1'b0;
    #2;
    forever begin
      #(half_a);
      if (ro_en) ro_in = ~ro_in;
      else ro_in = 1'b0;
    end
  end

  initial begin
    ro_in8 = 1'b0;
    #2;
    forever begin
      #(half_b);
      if (ro_en8) ro_in8 = ~ro_in8;
      else ro_in8 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a window of w clk cycles sees w/p rising edges of a p-cycle oscillator
  function automatic int model_edges(input int w, input int p);
    return w / p;
  endfunction

  function automatic bit model_flag(input int nominal, input int gmin, input int gmax,
                                    input int maxcnt);
    return (nominal > maxcnt) || (nominal < gmin) || (nominal > gmax);
  endfunction

  function automatic logic near(input int obs, input int nominal);
    return (obs >= nominal - 1) && (obs <= nominal + 1);
  endfunction

  // Pulse start on the 16-bit instance and follow it to done; j counts cycles after the start edge
  task automatic run_meas(input bit mid_start, output int lat, output int en_cycles);
    lat = -1;
    en_cycles = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4000; j++) begin
      if (j > 0) @(negedge clk);
      if (ro_en) en_cycles++;
      start = (mid_start && j == 300);
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_reject(output int done_at, output bit saw_busy, output bit saw_en);
    done_at = -1;
    saw_busy = 1'b0;
    saw_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (ro_en) saw_en = 1'b1;
      if (done && done_at < 0) done_at = j;
    end
  endtask

  int  lat, en_cycles, done_at, nominal, p, w, gmin, gmax, band;
  bit  saw_busy, saw_en, saw_done, exp_flag;

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; window_len = '0; golden_min = '0; golden_max = '0;
    start8 = 1'b0; abort8 = 1'b0; window_len8 = '0; golden_min8 = '0; golden_max8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {ro_en, busy, done, sat, trojan_flag, cfg_err}, 0);
    chk("reset_count", count, 0);

    // Nominal path: 40 ns oscillator, 1000-cycle window
    half_a = 20; window_len = 1000; golden_min = 240; golden_max = 260;
    run_meas(1'b0, lat, en_cycles);
    chk("nom_latency", lat, SETTLE + 1000 + 2);
    chk("nom_ro_en_cycles", en_cycles, SETTLE + 1000);
    chk("nom_count_250", near(int'(count), model_edges(1000, 4)), 1);
    chk("nom_trojan", trojan_flag, 0);
    chk("nom_sat", sat, 0);
    chk("nom_busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Payload delay: 50 ns oscillator falls below the band
    half_a = 25;
    run_meas(1'b0, lat, en_cycles);
    chk("slow_count_200", near(int'(count), model_edges(1000, 5)), 1);
    chk("slow_trojan", trojan_flag, 1);

    // Rejected configurations leave results alone
    window_len = 0;
    run_reject(done_at, saw_busy, saw_en);
    chk("wl0_done_at", done_at, 1);
    chk("wl0_cfg_err", cfg_err, 1);
    chk("wl0_busy_never", saw_busy, 0);
    chk("wl0_ro_en_never", saw_en, 0);
    chk("wl0_trojan_held", trojan_flag, 1);
    window_len = 1000; golden_min = 300; golden_max = 200;
    run_reject(done_at, saw_busy, saw_en);
    chk("band_inv_cfg_err", cfg_err, 1);
    chk("band_inv_done_at", done_at, 1);
    chk("band_inv_busy_never", saw_busy, 0);

    golden_min = 190; golden_max = 210;
    run_meas(1'b0, lat, en_cycles);
    chk("slow_band_count", near(int'(count), model_edges(1000, 5)), 1);
    chk("slow_band_trojan", trojan_flag, 0);
    chk("slow_band_cfg_clr", cfg_err, 0);

    // Narrow counter saturates
    half_b = 20; window_len8 = 2000; golden_min8 = 100; golden_max8 = 200;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    saw_done = 1'b0;
    for (int j = 0; j < 2100 && !saw_done; j++) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    chk("sat8_done_seen", saw_done, 1);
    chk("sat8_count", count8, 255);
    chk("sat8_sat", sat8, 1);
    chk("sat8_trojan", trojan_flag8, 1);

    // Abort 100 cycles into MEASURE
    half_a = 20; window_len = 1000; golden_min = 240; golden_max = 260;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= SETTLE + 100; j++) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_cfg_err", cfg_err, 0);
    saw_done = 1'b0;
    for (int j = 0; j < 1100; j++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    // Restart with a start pulse in the middle of the measurement
    run_meas(1'b1, lat, en_cycles);
    chk("restart_latency", lat, SETTLE + 1000 + 2);
    chk("restart_count", near(int'(count), model_edges(1000, 4)), 1);
    chk("restart_trojan", trojan_flag, 0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ro_en", ro_en, 0);

    // Asynchronous reset mid-MEASURE
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {ro_en, busy, done, sat, trojan_flag, cfg_err}, 0);
    chk("async_rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    run_meas(1'b0, lat, en_cycles);
    chk("post_rst_latency", lat, SETTLE + 1000 + 2);
    chk("post_rst_count", near(int'(count), model_edges(1000, 4)), 1);

    // Randomized oscillator periods, windows and bands
    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 3))
        0: p = 4;
        1: p = 5;
        2: p = 6;
        default: p = 8;
      endcase
      w = p * int'($urandom_range(40, 120));
      nominal = model_edges(w, p);
      band = int'($urandom_range(0, 2));
      if (band == 0) begin
        gmin = nominal - int'($urandom_range(2, 10));
        gmax = nominal + int'($urandom_range(2, 10));
      end else if (band == 1) begin
        gmin = nominal + int'($urandom_range(2, 10));
        gmax = gmin + int'($urandom_range(0, 20));
      end else begin
        gmax = nominal - int'($urandom_range(2, 10));
        gmin = gmax - int'($urandom_range(0, 20));
      end
      exp_flag = model_flag(nominal, gmin, gmax, 65535);
      half_a = p * 5;
      window_len = 20'(w);
      golden_min = 16'(gmin);
      golden_max = 16'(gmax);
      run_meas(1'b0, lat, en_cycles);
      chk("rand_latency", lat, SETTLE + w + 2);
      chk("rand_ro_en_cycles", en_cycles, SETTLE + w);
      chk("rand_count", near(int'(count), nominal), 1);
      chk("rand_trojan", trojan_flag, 32'(exp_flag));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
